// File: rtl/led_panel_scan_ctrl.sv
// Row-scan sequencer for a 1-bit-per-colour LED panel: fetches pixel bits from a
// 1-cycle-latency frame buffer, shifts them out, then blanks, latches, steps the row and dwells.
module led_panel_scan_ctrl #(
    parameter int COLS        = 32,
    parameter int ROWS        = 16,
    parameter int HOLD_CYCLES = 16,
    parameter int AW          = $clog2(ROWS) + $clog2(COLS)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          enable,
    output logic [AW-1:0] pix_addr,
    input  logic [2:0]    pix_rgb,
    output logic          red_out,
    output logic          green_out,
    output logic          blue_out,
    output logic          sclk_out,
    output logic          latch_out,
    output logic          blank_out,
    output logic          aclk_out,
    output logic          arst_out,
    output logic          busy,
    output logic          frame_done
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
    localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);

    typedef enum logic [2:0] {
        IDLE, PREFETCH, SHIFT_LO, SHIFT_HI, BLANK, LATCH, ROWSTEP, HOLD
    } state_t;

    state_t        state;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [HW-1:0] hold_cnt;

    logic [RW-1:0] row_inc;
    logic [CW-1:0] col_inc;
    logic [CW-1:0] col_inc2;

    assign row_inc  = row + 1'b1;
    assign col_inc  = col + 1'b1;
    assign col_inc2 = col + CW'(2);

    // The address for a column is presented one cycle before the data is needed, so the
    // read for column c+1 is issued as column c enters SHIFT_LO, and the next row's
    // column 0 is issued on entry to ROWSTEP (IDLE parks the address at row 0, column 0).
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            row        <= '0;
            col        <= '0;
            hold_cnt   <= '0;
            pix_addr   <= '0;
            red_out    <= 1'b0;
            green_out  <= 1'b0;
            blue_out   <= 1'b0;
            sclk_out   <= 1'b0;
            latch_out  <= 1'b0;
            blank_out  <= 1'b1;
            aclk_out   <= 1'b0;
            arst_out   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            latch_out  <= 1'b0;
            aclk_out   <= 1'b0;
            arst_out   <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= PREFETCH;
                        busy  <= 1'b1;
                    end
                end
                PREFETCH: begin
                    state                            <= SHIFT_LO;
                    col                              <= '0;
                    {red_out, green_out, blue_out}   <= pix_rgb;
                    pix_addr                         <= {row, col_inc};
                end
                SHIFT_LO: begin
                    state    <= SHIFT_HI;
                    sclk_out <= 1'b1;
                end
                SHIFT_HI: begin
                    sclk_out <= 1'b0;
                    if (col == COL_LAST) begin
                        col       <= '0;
                        state     <= BLANK;
                        blank_out <= 1'b1;
                    end else begin
                        col                            <= col_inc;
                        state                          <= SHIFT_LO;
                        {red_out, green_out, blue_out} <= pix_rgb;
                        pix_addr                       <= {row, col_inc2};
                    end
                end
                BLANK: begin
                    state      <= LATCH;
                    latch_out  <= 1'b1;
                    frame_done <= (row == ROW_LAST);
                end
                LATCH: begin
                    state    <= ROWSTEP;
                    arst_out <= (row == '0);
                    aclk_out <= (row != '0);
                    pix_addr <= {row_inc, {CW{1'b0}}};
                end
                ROWSTEP: begin
                    if (HOLD_CYCLES > 0) begin
                        row       <= row_inc;
                        state     <= HOLD;
                        hold_cnt  <= HOLD_LAST;
                        blank_out <= 1'b0;
                    end else if (enable) begin
                        row   <= row_inc;
                        state <= PREFETCH;
                    end else begin
                        row       <= '0;
                        state     <= IDLE;
                        blank_out <= 1'b1;
                        busy      <= 1'b0;
                        pix_addr  <= '0;
                    end
                end
                HOLD: begin
                    if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end else if (enable) begin
                        state <= PREFETCH;
                    end else begin
                        row       <= '0;
                        state     <= IDLE;
                        blank_out <= 1'b1;
                        busy      <= 1'b0;
                        pix_addr  <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_panel_scan_ctrl.sv
// Scoreboard bench for led_panel_scan_ctrl: a row-level model queues expected shift, latch and
// row-step events; a negedge monitor pops and compares them as the DUT emits them.
module tb_led_panel_scan_ctrl;

    localparam int COLS = 4;
    localparam int ROWS = 4;
    localparam int HOLD = 2;
    localparam int AW   = $clog2(ROWS) + $clog2(COLS);
    localparam int P    = 1 + 2 * COLS + 3 + HOLD;
    localparam int P0   = 2 * COLS + 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n = 1'b0;
    logic          enable  = 1'b0;
    logic          enable0 = 1'b0;
    logic [AW-1:0] pix_addr, pix_addr0;
    logic [2:0]    pix_rgb, pix_rgb0;
    logic red_out, green_out, blue_out, sclk_out, latch_out, blank_out;
    logic aclk_out, arst_out, busy, frame_done;
    logic red_out0, green_out0, blue_out0, sclk_out0, latch_out0, blank_out0;
    logic aclk_out0, arst_out0, busy0, frame_done0;

    led_panel_scan_ctrl #(.COLS(COLS), .ROWS(ROWS), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .pix_addr(pix_addr), .pix_rgb(pix_rgb),
        .red_out(red_out), .green_out(green_out), .blue_out(blue_out), .sclk_out(sclk_out),
        .latch_out(latch_out), .blank_out(blank_out), .aclk_out(aclk_out), .arst_out(arst_out),
        .busy(busy), .frame_done(frame_done)
    );

    led_panel_scan_ctrl #(.COLS(COLS), .ROWS(ROWS), .HOLD_CYCLES(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .enable(enable0), .pix_addr(pix_addr0), .pix_rgb(pix_rgb0),
        .red_out(red_out0), .green_out(green_out0), .blue_out(blue_out0), .sclk_out(sclk_out0),
        .latch_out(latch_out0), .blank_out(blank_out0), .aclk_out(aclk_out0), .arst_out(arst_out0),
        .busy(busy0), .frame_done(frame_done0)
    );

    // Frame buffer: synchronous read, one cycle of latency.
    logic [2:0] mem [ROWS*COLS];
    always @(posedge clk) begin
        pix_rgb  <= mem[pix_addr];
        pix_rgb0 <= mem[pix_addr0];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;   // 0 = shift column, 1 = latch, 2 = row step
        int row;
        int col;
        int val;
    } ev_t;

    ev_t sb[$];
    int  checks = 0;
    int  errors = 0;

    int  en_cyc = 0;
    bit  first_pending = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic get_ev(input int kind, output ev_t e, output bit ok);
        checks++;
        ok = 1'b0;
        e  = '{0, 0, 0, 0};
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL event_kind%0d: got unexpected event, expected nothing queued (cycle %0d)", kind, cyc);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind) begin
                errors++;
                $display("FAIL event_order: got kind %0d, expected kind %0d row %0d col %0d (cycle %0d)",
                         kind, e.kind, e.row, e.col, cyc);
            end else begin
                ok = 1'b1;
            end
        end
    endtask

    // Reference model: what one complete row scan of row r must look like on the panel pins.
    function automatic void push_row(input int r);
        for (int c = 0; c < COLS; c++) sb.push_back('{0, r, c, int'(mem[r*COLS + c])});
        sb.push_back('{1, r, 0, (r == ROWS - 1) ? 1 : 0});
        sb.push_back('{2, r, 0, (r == 0) ? 1 : 0});
    endfunction

    // Main monitor.
    bit prev_sclk = 1'b0, have_latch = 1'b0;
    int last_sclk = 0, last_latch = 0, hold_left = 0;

    always @(negedge clk) begin
        ev_t e;
        bit  ok;
        if (!reset_n) begin
            prev_sclk     = 1'b0;
            have_latch    = 1'b0;
            hold_left     = 0;
            first_pending = 1'b0;
        end else begin
            if (hold_left > 0) begin
                chk("hold_blank_low", int'(blank_out), 0);
                hold_left--;
            end
            if ((latch_out || aclk_out || arst_out || frame_done) && sclk_out) begin
                checks++; errors++;
                $display("FAIL strobe_with_sclk: got sclk_out=1 with a strobe, expected sclk_out=0 (cycle %0d)", cyc);
            end
            if (sclk_out && !prev_sclk) begin
                if (first_pending) begin
                    chk("first_sclk_latency", cyc - en_cyc, 3);
                    first_pending = 1'b0;
                end
                get_ev(0, e, ok);
                if (ok) begin
                    chk($sformatf("rgb_r%0d_c%0d", e.row, e.col),
                        int'({red_out, green_out, blue_out}), e.val);
                    chk($sformatf("addr_r%0d_c%0d", e.row, e.col),
                        int'(pix_addr), e.row * COLS + (e.col + 1) % COLS);
                end
                last_sclk = cyc;
            end
            if (latch_out) begin
                get_ev(1, e, ok);
                if (ok) chk($sformatf("frame_done_r%0d", e.row), int'(frame_done), e.val);
                chk("latch_after_last_sclk", cyc - last_sclk, 2);
                chk("latch_blank", int'(blank_out), 1);
                if (have_latch) chk("row_period", cyc - last_latch, P);
                have_latch = 1'b1;
                last_latch = cyc;
            end else if (frame_done) begin
                checks++; errors++;
                $display("FAIL frame_done_alone: got frame_done=1 with latch_out=0, expected no pulse (cycle %0d)", cyc);
            end
            if (aclk_out || arst_out) begin
                get_ev(2, e, ok);
                if (ok) begin
                    chk($sformatf("arst_r%0d", e.row), int'(arst_out), e.val);
                    chk($sformatf("aclk_r%0d", e.row), int'(aclk_out), 1 - e.val);
                end
                chk("step_after_latch", cyc - last_latch, 1);
                chk("step_blank", int'(blank_out), 1);
                hold_left = HOLD;
            end
            if (!busy) have_latch = 1'b0;
            prev_sclk = sclk_out;
        end
    end

    // Monitor for the zero-dwell instance, which runs continuously.
    bit prev_sclk0 = 1'b0, have0 = 1'b0, havefd0 = 1'b0, step_pending0 = 1'b0;
    int last0 = 0, lastfd0 = 0, step0 = 0, row0 = 0, col0 = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_sclk0 = 1'b0; have0 = 1'b0; havefd0 = 1'b0; step_pending0 = 1'b0;
            row0 = 0; col0 = 0;
        end else begin
            if (sclk_out0 && !prev_sclk0) begin
                chk($sformatf("h0_rgb_r%0d_c%0d", row0, col0),
                    int'({red_out0, green_out0, blue_out0}), int'(mem[row0*COLS + col0]));
                chk("h0_shift_blank", int'(blank_out0), 1);
                if (step_pending0) begin
                    chk("h0_prefetch_after_step", cyc - step0, 3);
                    step_pending0 = 1'b0;
                end
                col0++;
            end
            if (latch_out0) begin
                if (have0) chk("h0_row_period", cyc - last0, P0);
                have0 = 1'b1;
                last0 = cyc;
                chk("h0_latch_blank", int'(blank_out0), 1);
                chk("h0_busy", int'(busy0), 1);
                chk("h0_cols_shifted", col0, COLS);
            end
            if (frame_done0) begin
                if (havefd0) chk("h0_frame_period", cyc - lastfd0, P0 * ROWS);
                havefd0 = 1'b1;
                lastfd0 = cyc;
            end
            if (aclk_out0 || arst_out0) begin
                chk($sformatf("h0_arst_r%0d", row0), int'(arst_out0), (row0 == 0) ? 1 : 0);
                chk("h0_step_blank", int'(blank_out0), 1);
                step0 = cyc;
                step_pending0 = 1'b1;
                row0 = (row0 + 1) % ROWS;
                col0 = 0;
            end
            prev_sclk0 = sclk_out0;
        end
    end

    task automatic check_idle(input string name, input bit full);
        chk({name, "_blank"}, int'(blank_out), 1);
        chk({name, "_strobes"}, int'({sclk_out, latch_out, aclk_out, arst_out, frame_done, busy}), 0);
        if (full) begin
            chk({name, "_rgb"}, int'({red_out, green_out, blue_out}), 0);
            chk({name, "_addr"}, int'(pix_addr), 0);
        end
    endtask

    // Scan n rows from idle, dropping enable at a random point inside the last row.
    task automatic run(input int n);
        int k, w;
        for (int i = 0; i < n; i++) push_row(i % ROWS);
        @(posedge clk); #1;
        enable        = 1'b1;
        en_cyc        = cyc;
        first_pending = 1'b1;
        k = 1 + (n - 1) * P + int'($urandom_range(0, P - 1));
        repeat (k) @(posedge clk);
        #1 enable = 1'b0;
        w = 0;
        while (busy && w < 4 * P) begin
            @(posedge clk); #1;
            w++;
        end
        chk("return_to_idle", int'(busy), 0);
        repeat (3) begin
            @(posedge clk); #1;
            check_idle("post_run_idle", 1'b0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, expected the bench to finish");
        $fatal(1);
    end

    initial begin
        int m, cnt, w;
        for (int i = 0; i < ROWS * COLS; i++) mem[i] = 3'($urandom_range(0, 7));
        mem[0] = 3'd4; mem[1] = 3'd2; mem[2] = 3'd1; mem[3] = 3'd7;

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            check_idle("reset_idle", 1'b1);
        end
        enable0 = 1'b1;

        run(1);
        for (int t = 0; t < 6; t++) run(int'($urandom_range(1, 2 * ROWS + 1)));
        run(2 * ROWS);

        // Reset asserted while sclk is high.
        push_row(0);
        @(posedge clk); #1;
        enable        = 1'b1;
        en_cyc        = cyc;
        first_pending = 1'b1;
        m = int'($urandom_range(1, COLS));
        cnt = 0;
        w = 0;
        while (cnt < m && w < 4 * P) begin
            @(posedge clk); #1;
            w++;
            if (sclk_out) cnt++;
        end
        chk("reach_shift_hi", cnt, m);
        reset_n = 1'b0;
        enable  = 1'b0;
        @(posedge clk); #1;
        check_idle("reset_mid_shift", 1'b1);
        sb.delete();
        @(posedge clk); #1 reset_n = 1'b1;

        run(3);
        repeat (2 * P0) @(posedge clk);
        #1 chk("queue_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
